// File: rtl/interrupt_controller_if.sv
// Decoder/PC-mux side of the trap responder: trap strobes, IRQ lines, redirect and status.
interface interrupt_controller_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_IRQ = 3
);
  logic [NUM_IRQ-1:0] irq_in;
  logic [WIDTH-1:0]   pc_next;
  logic               halt;
  logic               ecall;
  logic               uret;
  logic               sti;
  logic               cli;
  logic               pc_redirect;
  logic [WIDTH-1:0]   pc_target;
  logic [WIDTH-1:0]   epc;
  logic [3:0]         cause;
  logic               ie;
  logic               in_trap;
  logic [NUM_IRQ-1:0] pending;
  logic               trap_err;

  modport master (
    output irq_in, pc_next, halt, ecall, uret, sti, cli,
    input  pc_redirect, pc_target, epc, cause, ie, in_trap, pending, trap_err
  );

  modport slave (
    input  irq_in, pc_next, halt, ecall, uret, sti, cli,
    output pc_redirect, pc_target, epc, cause, ie, in_trap, pending, trap_err
  );
endinterface

// File: rtl/interrupt_controller.sv
// Single-level trap/interrupt responder: latches IRQ edges, arbitrates ecall vs IRQ and
// steers the PC mux to a vector on entry or to the saved EPC on uret.
module interrupt_controller #(
  parameter int               WIDTH    = 32,
  parameter int               NUM_IRQ  = 3,
  parameter logic [WIDTH-1:0] VEC_BASE = 'h100
) (
  input logic                 clk,
  input logic                 rst_n,
  interrupt_controller_if.slave bus
);

  typedef enum logic {IDLE, IN_TRAP} state_t;

  state_t             state_reg;
  logic [NUM_IRQ-1:0] sync1_reg, sync2_reg, sync3_reg;
  logic [NUM_IRQ-1:0] pending_reg;
  logic [NUM_IRQ-1:0] irq_edge, take_mask;
  logic               ie_reg, pie_reg, trap_err_reg;
  logic [WIDTH-1:0]   epc_reg;
  logic [3:0]         cause_reg;

  logic [3:0]         irq_sel;
  logic               irq_any;
  logic               take_ecall, take_irq, take_uret, proto_err;
  logic               redirect_next;
  logic [WIDTH-1:0]   target_next;

  // sync3 holds the previous synchronized level so a held line is pended only once
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_irq
      assign irq_edge[gi]  = sync2_reg[gi] & ~sync3_reg[gi];
      assign take_mask[gi] = take_irq && (irq_sel == 4'(gi));
    end
  endgenerate

  always_comb begin
    irq_any = 1'b0;
    irq_sel = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        irq_any = 1'b1;
        irq_sel = 4'(i);
      end
    end
  end

  always_comb begin
    take_ecall = (state_reg == IDLE) && bus.ecall;
    take_irq   = (state_reg == IDLE) && ie_reg && !bus.halt && !bus.ecall && !bus.uret && irq_any;
    take_uret  = (state_reg == IN_TRAP) && bus.uret;
    proto_err  = ((state_reg == IDLE) && bus.uret) ||
                 ((state_reg == IN_TRAP) && bus.ecall && !bus.uret);
    target_next = '0;
    if (take_ecall)
      target_next = VEC_BASE;
    else if (take_irq)
      target_next = VEC_BASE + WIDTH'({irq_sel + 4'd1, 2'b00});
    else if (take_uret)
      target_next = epc_reg;
    // Held in reset the mux must never be steered, whatever the decoder shows
    redirect_next = rst_n && (take_ecall || take_irq || take_uret);
  end

  assign bus.pc_redirect = redirect_next;
  assign bus.pc_target   = redirect_next ? target_next : '0;
  assign bus.epc         = epc_reg;
  assign bus.cause       = cause_reg;
  assign bus.ie          = ie_reg;
  assign bus.in_trap     = (state_reg == IN_TRAP);
  assign bus.pending     = pending_reg;
  assign bus.trap_err    = trap_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      sync3_reg    <= '0;
      pending_reg  <= '0;
      ie_reg       <= 1'b0;
      pie_reg      <= 1'b0;
      trap_err_reg <= 1'b0;
      epc_reg      <= '0;
      cause_reg    <= 4'd0;
    end else begin
      sync1_reg   <= bus.irq_in;
      sync2_reg   <= sync1_reg;
      sync3_reg   <= sync2_reg;
      // A fresh edge on the source being taken re-arms it
      pending_reg <= (pending_reg & ~take_mask) | irq_edge;
      if (proto_err)
        trap_err_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (take_ecall || take_irq) begin
            epc_reg   <= bus.pc_next;
            cause_reg <= take_ecall ? 4'd1 : 4'd2 + irq_sel;
            pie_reg   <= ie_reg;
            ie_reg    <= 1'b0;
            state_reg <= IN_TRAP;
          end else if (bus.cli) begin
            ie_reg <= 1'b0;
          end else if (bus.sti) begin
            ie_reg <= 1'b1;
          end
        end
        IN_TRAP: begin
          if (take_uret) begin
            ie_reg    <= pie_reg;
            cause_reg <= 4'd0;
            state_reg <= IDLE;
          end else if (bus.cli) begin
            ie_reg <= 1'b0;
          end else if (bus.sti) begin
            ie_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboarded bench for interrupt_controller: expectations are queued as stimulus is
// applied and drained against the DUT outputs once they are valid.
`timescale 1ns/1ps
module tb_interrupt_controller;

  localparam int S_REDIR  = 0;
  localparam int S_TGT    = 1;
  localparam int S_EPC    = 2;
  localparam int S_CAUSE  = 3;
  localparam int S_IE     = 4;
  localparam int S_INTRAP = 5;
  localparam int S_PEND   = 6;
  localparam int S_ERR    = 7;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  interrupt_controller_if #(.WIDTH(32), .NUM_IRQ(3)) bus ();

  interrupt_controller #(
    .WIDTH   (32),
    .NUM_IRQ (3),
    .VEC_BASE(32'h100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_REDIR:  return {31'd0, bus.pc_redirect};
      S_TGT:    return bus.pc_target;
      S_EPC:    return bus.epc;
      S_CAUSE:  return {28'd0, bus.cause};
      S_IE:     return {31'd0, bus.ie};
      S_INTRAP: return {31'd0, bus.in_trap};
      S_PEND:   return {29'd0, bus.pending};
      S_ERR:    return {31'd0, bus.trap_err};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic expect_val(string tag, int sel, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clr();
    bus.ecall = 1'b0;
    bus.uret  = 1'b0;
    bus.sti   = 1'b0;
    bus.cli   = 1'b0;
  endtask

  task automatic expect_redir(string tag, logic r, logic [31:0] t);
    expect_val({tag, "_redir"}, S_REDIR, {31'd0, r});
    expect_val({tag, "_tgt"}, S_TGT, t);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.irq_in  = 3'b000;
    bus.pc_next = 32'h0;
    bus.halt    = 1'b0;
    clr();
    bus.ecall   = 1'b1;

    // Reset: outputs zero even with an ecall on the decoder
    #12;
    expect_redir("rst", 1'b0, 32'h0);
    expect_val("rst_epc", S_EPC, 32'h0);
    expect_val("rst_cause", S_CAUSE, 32'h0);
    expect_val("rst_ie", S_IE, 32'h0);
    expect_val("rst_intrap", S_INTRAP, 32'h0);
    expect_val("rst_pend", S_PEND, 32'h0);
    expect_val("rst_err", S_ERR, 32'h0);
    drain();
    bus.ecall = 1'b0;
    #8 rst_n = 1'b1;
    cyc();

    // 1: irq1 with ie=0, then sti
    bus.irq_in = 3'b010;
    cycn(2);
    expect_val("irq_lat_2edges", S_PEND, 32'h0);
    drain();
    cyc();
    expect_val("irq_lat_3edges", S_PEND, 32'h2);
    expect_redir("ie0_blocks", 1'b0, 32'h0);
    drain();
    bus.sti = 1'b1;
    #1 expect_redir("sti_cycle", 1'b0, 32'h0);
    drain();
    cyc(); clr();
    expect_val("sti_ie", S_IE, 32'h1);
    bus.pc_next = 32'h20;
    #1 expect_redir("irq1_take", 1'b1, 32'h108);
    drain();
    cyc();
    expect_val("irq1_cause", S_CAUSE, 32'h3);
    expect_val("irq1_ie", S_IE, 32'h0);
    expect_val("irq1_intrap", S_INTRAP, 32'h1);
    expect_val("irq1_epc", S_EPC, 32'h20);
    expect_val("irq1_pend", S_PEND, 32'h0);
    drain();
    bus.uret = 1'b1;
    #1 expect_redir("uret1", 1'b1, 32'h20);
    drain();
    cyc(); clr();
    expect_val("uret1_ie", S_IE, 32'h1);
    expect_val("uret1_intrap", S_INTRAP, 32'h0);
    expect_val("uret1_cause", S_CAUSE, 32'h0);
    drain();

    // 2: pending 101, lowest index first, irq2 right after uret
    bus.cli = 1'b1;
    cyc(); clr();
    bus.irq_in = 3'b111;
    cycn(3);
    expect_val("pend_101", S_PEND, 32'h5);
    drain();
    bus.sti = 1'b1;
    cyc(); clr();
    bus.pc_next = 32'h40;
    #1 expect_redir("irq0_take", 1'b1, 32'h104);
    drain();
    cyc();
    expect_val("irq0_epc", S_EPC, 32'h40);
    expect_val("irq0_pend", S_PEND, 32'h4);
    expect_val("irq0_cause", S_CAUSE, 32'h2);
    drain();
    bus.uret = 1'b1;
    #1 expect_redir("uret2", 1'b1, 32'h40);
    drain();
    cyc(); clr();
    expect_val("uret2_ie", S_IE, 32'h1);
    bus.pc_next = 32'h44;
    #1 expect_redir("irq2_take", 1'b1, 32'h10C);
    drain();
    cyc();
    expect_val("irq2_cause", S_CAUSE, 32'h4);
    expect_val("irq2_pend", S_PEND, 32'h0);
    drain();
    bus.uret = 1'b1;
    cyc(); clr();

    // 3: halt blocks irq; ecall beats pending irq0 even under halt
    bus.irq_in = 3'b110;
    cycn(3);
    bus.halt   = 1'b1;
    bus.irq_in = 3'b111;
    cycn(3);
    expect_val("halt_pend", S_PEND, 32'h1);
    #1 expect_redir("halt_blocks", 1'b0, 32'h0);
    drain();
    bus.ecall   = 1'b1;
    bus.pc_next = 32'h2C;
    #1 expect_redir("ecall_take", 1'b1, 32'h100);
    drain();
    cyc(); clr();
    expect_val("ecall_cause", S_CAUSE, 32'h1);
    expect_val("ecall_pend", S_PEND, 32'h1);
    expect_val("ecall_intrap", S_INTRAP, 32'h1);
    expect_val("ecall_epc", S_EPC, 32'h2C);
    expect_val("ecall_ie", S_IE, 32'h0);
    drain();

    // 4: ecall inside trap is an error without redirect
    bus.ecall = 1'b1;
    #1 expect_redir("ecall_in_trap", 1'b0, 32'h0);
    drain();
    cyc(); clr();
    expect_val("ecall_in_trap_err", S_ERR, 32'h1);
    expect_val("ecall_in_trap_state", S_INTRAP, 32'h1);
    drain();
    bus.halt = 1'b0;
    bus.uret = 1'b1;
    #1 expect_redir("uret3", 1'b1, 32'h2C);
    drain();
    cyc(); clr();
    expect_val("uret3_ie", S_IE, 32'h1);
    #1 expect_redir("irq_after_uret", 1'b1, 32'h104);
    drain();
    cyc();
    expect_val("irq_after_uret_pend", S_PEND, 32'h0);
    drain();
    bus.uret = 1'b1;
    cyc(); clr();

    // 5: sti+cli -> cli wins; edge coinciding with take keeps pending
    bus.sti = 1'b1;
    bus.cli = 1'b1;
    cyc(); clr();
    expect_val("sti_cli_ie", S_IE, 32'h0);
    drain();
    bus.irq_in = 3'b110;
    cycn(3);
    bus.irq_in = 3'b111;
    cycn(3);
    bus.irq_in = 3'b110;
    cycn(3);
    bus.halt = 1'b1;
    bus.sti  = 1'b1;
    cyc(); clr();
    expect_val("setwin_ie", S_IE, 32'h1);
    expect_val("setwin_pend_pre", S_PEND, 32'h1);
    drain();
    bus.irq_in = 3'b111;
    cycn(2);
    bus.halt = 1'b0;
    #1 expect_redir("setwin_take", 1'b1, 32'h104);
    drain();
    cyc();
    expect_val("set_wins_pend", S_PEND, 32'h1);
    expect_val("set_wins_cause", S_CAUSE, 32'h2);
    drain();
    bus.uret = 1'b1;
    cyc(); clr();
    #1 expect_redir("rearmed_take", 1'b1, 32'h104);
    drain();
    cyc();
    expect_val("rearmed_pend", S_PEND, 32'h0);
    drain();
    bus.uret = 1'b1;
    cyc(); clr();

    // 6: async reset while in trap
    bus.ecall   = 1'b1;
    bus.pc_next = 32'h80;
    cyc(); clr();
    expect_val("pre_rst_epc", S_EPC, 32'h80);
    expect_val("pre_rst_intrap", S_INTRAP, 32'h1);
    drain();
    #2;
    rst_n    = 1'b0;
    bus.uret = 1'b1;
    #1;
    expect_redir("async_rst", 1'b0, 32'h0);
    expect_val("async_rst_epc", S_EPC, 32'h0);
    expect_val("async_rst_cause", S_CAUSE, 32'h0);
    expect_val("async_rst_ie", S_IE, 32'h0);
    expect_val("async_rst_intrap", S_INTRAP, 32'h0);
    expect_val("async_rst_pend", S_PEND, 32'h0);
    expect_val("async_rst_err", S_ERR, 32'h0);
    drain();
    cyc();
    clr();
    rst_n = 1'b1;
    cyc();
    expect_val("post_rst_intrap", S_INTRAP, 32'h0);
    expect_redir("post_rst", 1'b0, 32'h0);
    drain();
    bus.uret = 1'b1;
    #1 expect_redir("uret_idle", 1'b0, 32'h0);
    drain();
    cyc(); clr();
    expect_val("uret_idle_err", S_ERR, 32'h1);
    expect_val("uret_idle_intrap", S_INTRAP, 32'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
